serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Companion to the combinational adder chain: it inverts the add operation with one cell reused over WIDTH cycles instead of a ripple chain.
- Sits in the arithmetic datapath where area matters more than latency.
- Simple start/busy/done handshake toward the controller.

---
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell reused over WIDTH clocks, LSB first.
// Optional borrow-in port `bin` is enabled by defining SERIAL_SUB_BORROW_IN_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic             bin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_partial;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bor;
  logic             r_borrow_out;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bor_next;
  logic             w_bin;
  logic [WIDTH-1:0] w_shift;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign w_bin = bin;
`else
  assign w_bin = 1'b0;
`endif

  assign w_d        = r_a_sh[0] ^ r_b_sh[0] ^ r_bor;
  assign w_bor_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_bor);
  // Partial result holds WIDTH-1 bits; the final bit joins it directly into diff.
  assign w_shift    = {w_d, r_partial};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_partial    <= '0;
      r_diff       <= '0;
      r_cnt        <= '0;
      r_bor        <= 1'b0;
      r_borrow_out <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a_sh <= a;
        r_b_sh <= b;
        r_bor  <= w_bin;
        r_cnt  <= '0;
      end else if (r_state == S_RUN) begin
        r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
        r_bor     <= w_bor_next;
        r_partial <= w_shift[WIDTH-1:1];
        r_cnt     <= r_cnt + 1'b1;
        if (w_last) begin
          r_diff       <= w_shift;
          r_borrow_out <= w_bor_next;
        end
      end
    end
  end

  assign busy       = (r_state == S_RUN);
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a monitor pops on done.
// Honours SERIAL_SUB_BORROW_IN_EN when the design is built with it.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin_v = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         ebin;
    logic [W-1:0] d;
    logic         bo;
    int           due;
  } exp_t;

  exp_t sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef SERIAL_SUB_BORROW_IN_EN
    .bin        (bin_v),
`endif
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain (W+1)-bit unsigned arithmetic; the extra bit is the borrow out.
  function automatic void push(input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic ibin, input int due);
    logic [W:0] full;
    logic       eff;
    exp_t       e;
`ifdef SERIAL_SUB_BORROW_IN_EN
    eff = ibin;
`else
    eff = 1'b0;
`endif
    full   = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, eff};
    e.ea   = ia;
    e.eb   = ib;
    e.ebin = eff;
    e.d    = full[W-1:0];
    e.bo   = full[W];
    e.due  = due;
    sb.push_back(e);
  endfunction

  // Monitor: expected busy is derived from the outstanding operations' acceptance windows.
  exp_t m_e;
  logic m_busy;
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_busy = 1'b0;
      foreach (sb[i]) if ((sb[i].due - W) <= cyc && cyc < sb[i].due) m_busy = 1'b1;
      checks++;
      if (busy !== m_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d actual=%b required=%b", cyc, busy, m_busy);
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cyc=%0d diff=%0d borrow=%b required=no done", cyc, diff, borrow_out);
        end else begin
          m_e = sb.pop_front();
          checks += 3;
          if (cyc != m_e.due) begin
            errors++;
            $display("FAIL done_cycle actual=%0d required=%0d", cyc, m_e.due);
          end
          if (diff !== m_e.d) begin
            errors++;
            $display("FAIL diff a=%0d b=%0d bin=%b actual=%0d required=%0d", m_e.ea, m_e.eb, m_e.ebin, diff, m_e.d);
          end
          if (borrow_out !== m_e.bo) begin
            errors++;
            $display("FAIL borrow_out a=%0d b=%0d bin=%b actual=%b required=%b", m_e.ea, m_e.eb, m_e.ebin, borrow_out, m_e.bo);
          end
          $display("txn cyc=%0d a=%0d b=%0d bin=%b -> diff=%0d borrow=%b (model %0d/%b)",
                   cyc, m_e.ea, m_e.eb, m_e.ebin, diff, borrow_out, m_e.d, m_e.bo);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        m_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_done cyc=%0d actual=no done required=done at %0d", cyc, m_e.due);
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_wait actual=busy required=idle");
    end
    a     = ia;
    b     = ib;
    bin_v = ibin;
    start = 1'b1;
    push(ia, ib, ibin, cyc + 1 + W);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done actual=no done required=done");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual=pending %0d required=0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks += 4;
    if (busy !== 1'b0)       begin errors++; $display("FAIL %s_busy actual=%b required=0", tag, busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL %s_done actual=%b required=0", tag, done); end
    if (diff !== '0)         begin errors++; $display("FAIL %s_diff actual=%0d required=0", tag, diff); end
    if (borrow_out !== 1'b0) begin errors++; $display("FAIL %s_borrow actual=%b required=0", tag, borrow_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, including the borrow boundaries.
    issue(8'd5, 8'd3, 1'b0);
    issue(8'd3, 8'd5, 1'b0);
    issue(8'h00, 8'h01, 1'b0);
    issue(8'hA5, 8'hA5, 1'b0);
    wait_idle();

    // Starts during an operation must be ignored.
    issue(8'd9, 8'd4, 1'b0);
    @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start held high: operands change on the done cycle.
    @(negedge clk);
    a = 8'd200; b = 8'd100; bin_v = 1'b0; start = 1'b1;
    push(8'd200, 8'd100, 1'b0, cyc + 1 + W);
    wait_done();
    a = 8'd10; b = 8'd20;
    push(8'd10, 8'd20, 1'b0, cyc + 1 + W);
    wait_done();
    start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-operation aborts without a done pulse.
    issue(8'd77, 8'd12, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd50, 8'd60, 1'b0);
    wait_idle();

`ifdef SERIAL_SUB_BORROW_IN_EN
    issue(8'd5, 8'd3, 1'b1);
    issue(8'd0, 8'd0, 1'b1);
    wait_idle();
`endif

    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
